// File: rtl/seq_mult_pkg.sv
// Shared types for the sequential multiplier: FSM state encoding and counter sizing.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bit counter only has to reach WIDTH-1; keep at least one bit for WIDTH=2.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/seq_mult_param_if.sv
// Start/busy/done request bus between a requester (master) and the multiplier (slave).
interface seq_mult_param_if
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic [2*WIDTH-1:0] product;
  logic               busy;
  logic               done;

  modport master (
    output start, signed_mode, multiplicand, multiplier,
    input  product, busy, done
  );

  modport slave (
    input  start, signed_mode, multiplicand, multiplier,
    output product, busy, done
  );

endinterface

// File: rtl/seq_mult_magnitude.sv
// Combinational magnitude/sign split of one operand; raw value passes through when unsigned.
module seq_mult_magnitude #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_signed_mode,
  output logic [WIDTH-1:0] o_mag,
  output logic             o_sign
);

  assign o_sign = i_signed_mode & i_val[WIDTH-1];
  // -2^(WIDTH-1) negates to itself, which reads correctly as an unsigned magnitude.
  assign o_mag  = o_sign ? (~i_val + 1'b1) : i_val;

endmodule

// File: rtl/seq_mult_param.sv
// Shift-add multiplier, one multiplier bit per clock; done WIDTH cycles after start, start ignored unless IDLE.
// Define SEQ_MULT_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module seq_mult_param
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic            i_clk,
  input  logic            i_reset,
  seq_mult_param_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_mag_a;
  logic [WIDTH-1:0]   r_mplr;
  logic               r_neg;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_product;
  logic [CW-1:0]      r_cnt;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_sign_a;
  logic               w_sign_b;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_res;
  logic [WIDTH-1:0]   w_mplr_next;
  logic               w_last;
  logic               w_accept;

  seq_mult_magnitude #(.WIDTH(WIDTH)) u_mag_a (
    .i_val         (bus.multiplicand),
    .i_signed_mode (bus.signed_mode),
    .o_mag         (w_mag_a),
    .o_sign        (w_sign_a)
  );

  seq_mult_magnitude #(.WIDTH(WIDTH)) u_mag_b (
    .i_val         (bus.multiplier),
    .i_signed_mode (bus.signed_mode),
    .o_mag         (w_mag_b),
    .o_sign        (w_sign_b)
  );

  assign w_accept    = (r_state == IDLE) && bus.start;
  assign w_addend    = r_mplr[0] ? r_mag_a : {WIDTH{1'b0}};
  assign w_sum       = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_acc_next  = {w_sum, r_acc[WIDTH-1:1]};
  assign w_mplr_next = r_mplr >> 1;

`ifdef SEQ_MULT_EARLY_EXIT_EN
  assign w_last = (r_cnt == CW'(WIDTH-1)) || (w_mplr_next == {WIDTH{1'b0}});
  // Stopping early skips the remaining right shifts; apply them in one step.
  assign w_res  = w_acc_next >> (CW'(WIDTH-1) - r_cnt);
`else
  assign w_last = (r_cnt == CW'(WIDTH-1));
  assign w_res  = w_acc_next;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = CALC;
      CALC:    if (w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (r_state)
      CALC:    bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_mag_a   <= '0;
      r_mplr    <= '0;
      r_neg     <= 1'b0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_mag_a <= w_mag_a;
      r_mplr  <= w_mag_b;
      r_neg   <= w_sign_a ^ w_sign_b;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (r_state == CALC) begin
      r_acc  <= w_acc_next;
      r_mplr <= w_mplr_next;
      r_cnt  <= r_cnt + 1'b1;
      if (w_last) begin
        r_product <= r_neg ? -w_res : w_res;
      end
    end
  end

  assign bus.product = r_product;

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed bench for seq_mult_param (WIDTH=8): expected product/latency queued at start, checked at done.
module tb_seq_mult_param;

  localparam int W = 8;
`ifdef SEQ_MULT_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  logic [2*W-1:0] prod_q[$];
  int             lat_q[$];

  always #5 clk = ~clk;

  seq_mult_param_if #(.WIDTH(W)) bus ();

  seq_mult_param #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sm);
    logic signed [2*W-1:0] sa;
    logic signed [2*W-1:0] sb;
    if (sm) begin
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
    end else begin
      sa = {{W{1'b0}}, a};
      sb = {{W{1'b0}}, b};
    end
    return sa * sb;
  endfunction

  function automatic int exp_lat(input logic [W-1:0] b, input logic sm);
    logic [W-1:0] m;
    int h;
    m = (sm && b[W-1]) ? (~b + 1'b1) : b;
    h = 0;
    for (int i = 0; i < W; i++) if (m[i]) h = i;
    return EARLY ? h + 1 : W;
  endfunction

  // Called just after an edge with the DUT in IDLE; returns just after the DONE->IDLE edge.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sm, input logic [2*W-1:0] exp, input int inject);
    int             cyc;
    int             busy_cnt;
    logic           got;
    logic           held;
    logic [2*W-1:0] prev;
    logic [2*W-1:0] qp;
    logic [31:0]    rnd;
    int             ql;
    prod_q.push_back(exp);
    lat_q.push_back(exp_lat(b, sm));
    prev = bus.product;
    bus.start = 1'b1;
    bus.multiplicand = a;
    bus.multiplier = b;
    bus.signed_mode = sm;
    @(posedge clk); #1;
    rnd = $urandom;
    bus.start = 1'b0;
    bus.multiplicand = rnd[W-1:0];
    bus.multiplier = rnd[2*W-1:W];
    bus.signed_mode = ~sm;
    busy_cnt = bus.busy ? 1 : 0;
    held = (bus.product === prev);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      if (cyc == inject) begin
        bus.start = 1'b1;
        bus.multiplicand = 8'd3;
        bus.multiplier = 8'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (bus.done) got = 1'b1;
      else begin
        if (bus.busy) busy_cnt++;
        if (bus.product !== prev) held = 1'b0;
      end
    end
    check({tag, " done seen"}, 32'(got), 32'd1);
    qp = prod_q.pop_front();
    ql = lat_q.pop_front();
    check({tag, " product"}, 32'(bus.product), 32'(qp));
    check({tag, " latency"}, 32'(cyc), 32'(ql));
    check({tag, " busy cycles"}, 32'(busy_cnt), 32'(ql));
    check({tag, " busy low at done"}, 32'(bus.busy), 32'd0);
    check({tag, " product stable in calc"}, 32'(held), 32'd1);
    // A start presented while in DONE must not launch a new operation.
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, " done one cycle"}, 32'(bus.done), 32'd0);
    check({tag, " start ignored in done"}, 32'(bus.busy), 32'd0);
    check({tag, " product held"}, 32'(bus.product), 32'(qp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int          seen;
    logic [31:0] rnd;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.signed_mode = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset product", 32'(bus.product), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("u3x5", 8'd3, 8'd5, 1'b0, 16'd15, -1);
    run_op("u255x255", 8'd255, 8'd255, 1'b0, 16'hFE01, -1);
    run_op("s-7x6", 8'hF9, 8'd6, 1'b1, 16'hFFD6, -1);
    run_op("s-128x-128", 8'h80, 8'h80, 1'b1, 16'h4000, -1);
    run_op("s127x-128", 8'h7F, 8'h80, 1'b1, 16'hC080, -1);
    run_op("u10x12 restart", 8'd10, 8'd12, 1'b0, 16'd120, 3);

    // Reset pulse in the middle of an operation discards it.
    bus.start = 1'b1;
    bus.multiplicand = 8'd50;
    bus.multiplier = 8'd3;
    bus.signed_mode = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midreset busy before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midreset busy", 32'(bus.busy), 32'd0);
    check("midreset product", 32'(bus.product), 32'd0);
    check("midreset done", 32'(bus.done), 32'd0);
    seen = 0;
    repeat (W + 2) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen = 1;
    end
    check("midreset no done", 32'(seen), 32'd0);

    run_op("u2x2", 8'd2, 8'd2, 1'b0, 16'd4, -1);
    run_op("u200x0", 8'd200, 8'd0, 1'b0, 16'd0, -1);
    run_op("u9x4", 8'd9, 8'd4, 1'b0, 16'd36, -1);
    run_op("s5x-1", 8'd5, 8'hFF, 1'b1, 16'hFFFB, -1);

    for (int i = 0; i < 4; i++) begin
      rnd = $urandom;
      ra = rnd[W-1:0];
      rb = rnd[2*W-1:W];
      run_op("random", ra, rb, rnd[16], model(ra, rb, rnd[16]), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_mult_param.md
# seq_mult_param

Parametrised sequential shift-add multiplier, the next generation of the 4-bit unit. Operand width is configurable, the unit supports both unsigned and two's-complement operands, and a start/busy/done handshake is provided. It retires one multiplier bit per clock in the arithmetic datapath. The result is held stable until the next operation is accepted.

## Interface
- WIDTH, 8, operand width in bits (≥2); product is 2*WIDTH bits
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (one clock; reset sampled on rising clk)
- start  in  1  request; accepted only in IDLE
- signed_mode  in  1  1 = two's-complement operands/product, 0 = unsigned; sampled with start
- multiplicand  in  WIDTH  operand A; sampled with start
- multiplier  in  WIDTH  operand B; sampled with start
- product  out  2*WIDTH  result; held until next accepted start
- busy  out  1  high while an operation is in progress (CALC)
- done  out  1  one-cycle pulse when product is valid

## Operation
- States:
  - IDLE: waiting for start.
  - CALC: one multiplier bit per clock.
  - DONE: one cycle, done=1.
- IDLE + start=1 at an edge:
  - latch |A| and |B| (magnitudes when signed_mode=1, raw values otherwise);
  - latch neg = signed_mode & (A[msb] ^ B[msb]);
  - clear the accumulator and bit counter;
  - go to CALC; busy=1.
- CALC, each edge:
  - if the current LSB of the multiplier shift register is 1, add the magnitude of A into the upper half of the 2*WIDTH accumulator;
  - shift right by one; counter+1.
- Finish condition: the edge on which counter reaches WIDTH-1. At that edge:
  - product <= neg ? -acc_next : acc_next;
  - go to DONE; busy=0; done=1.
- DONE: the next edge returns to IDLE with done=0. start in DONE is ignored.
- start while busy or in DONE is ignored. Operand and mode changes after acceptance have no effect.
- Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1). It fits in WIDTH unsigned bits; no overflow is possible.
- Unsigned full range gives up to (2^WIDTH-1)^2. The product width is always sufficient.
- reset=0 at any edge, including mid-CALC:
  - state=IDLE, product=0, busy=0, done=0;
  - internal registers cleared; the in-flight operation is discarded.
- Reset values: product=0, busy=0, done=0.

## Timing
- Start accepted at edge k.
- busy is high after edge k through the finishing edge.
- done is high for exactly one cycle, after edge k+WIDTH (latency WIDTH cycles without early exit).
- Next start can be accepted at edge k+WIDTH+2 (first IDLE cycle). Throughput: one operation per WIDTH+2 cycles.
- product changes only on the finishing edge or on reset.

## Configuration
- SEQ_MULT_EARLY_EXIT_EN defined:
  - in CALC, finish also when the multiplier shift register after the current shift is all zeros;
  - latency = h+1 cycles, where h = index of the highest set bit of |B|; B=0 gives latency 1;
  - result is identical.
- Not defined: latency is fixed at WIDTH cycles for all operands.

## Structure
- Shared package seq_mult_pkg:
  - state enum (IDLE, CALC, DONE);
  - localparam helpers for the counter width, $clog2(WIDTH).
- One natural sub-module: seq_mult_magnitude, combinational. It takes a WIDTH operand and signed_mode, and returns the magnitude and sign bit. It is instantiated for A and B.

## Test plan
All cases use WIDTH=8, macro undefined unless stated.
- Unsigned 3*5 -> product=15, done exactly 8 cycles after the start edge, busy high for those 8 cycles.
- Unsigned 255*255 -> product=65025 (16'hFE01).
- Signed:
  - -7*6 -> 16'hFFD6 (-42);
  - -128*-128 -> 16'h4000 (16384);
  - 127*-128 -> 16'hC080.
- Mid-operation events:
  - start pulsed again 3 cycles into a 10*12 operation -> ignored, product=120;
  - reset=0 for one edge mid-CALC -> busy=0, product=0, no done pulse; next 2*2 -> 4.
- With SEQ_MULT_EARLY_EXIT_EN:
  - 200*0 -> product=0, done 1 cycle after start;
  - 9*4 -> 36, done after 3 cycles;
  - signed 5*-1 -> 16'hFFFB, done after 1 cycle (|B|=1).
